// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer read arbiter.
package fb_pkg;

    localparam int unsigned IMAGE_WIDTH  = 640;
    localparam int unsigned IMAGE_HEIGHT = 480;
    localparam int unsigned FB_DEPTH     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned FB_AW        = 19;
    localparam int unsigned PIX_W        = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        DONE
    } scan_state_e;

    typedef enum logic {
        OWN_DISP,
        OWN_SCAN
    } owner_e;

    // One in-flight read: who asked for it and which address it was.
    typedef struct packed {
        logic             valid;
        owner_e           owner;
        logic [FB_AW-1:0] addr;
    } rd_tag_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Delay line that carries a read tag alongside the frame-buffer read latency.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe_q [RD_LAT];

    // Shift tags one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/fb_scan_arbiter.sv
// Frame-buffer read-port arbiter: display has fixed priority, a background
// engine scans every pixel once per scan_start and streams it to the detector.
// Optional macro FB_SCAN_EARLY_STOP_EN: det_found during SCAN ends issuing early.
module fb_scan_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = fb_pkg::IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = fb_pkg::IMAGE_HEIGHT,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_start,
    input  logic             disp_req,
    input  logic [FB_AW-1:0] disp_addr,
    output logic             disp_rvalid,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [PIX_W-1:0] fb_rdata,
    output logic [FB_AW-1:0] scan_addr,
    output logic [PIX_W-1:0] scan_pixel,
    output logic             scan_valid,
    output logic             det_clear_n,
    input  logic             det_found,
    output logic             scan_busy,
    output logic             scan_done
);

    localparam int unsigned      DEPTH     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(DEPTH - 1);
    // DRAIN also covers the scan output register, so scan_done follows the last beat.
    localparam logic [2:0]       DRAIN_END = 3'(RD_LAT);

    scan_state_e      state_q, state_d;
    logic [FB_AW-1:0] ptr_q, ptr_d;
    logic [2:0]       drain_q, drain_d;
    logic             issue_scan;
    logic             early_stop;

    rd_tag_t tag_in, tag_out;

    logic             scan_valid_q;
    logic [FB_AW-1:0] scan_addr_q;
    logic [PIX_W-1:0] scan_pixel_q;

`ifdef FB_SCAN_EARLY_STOP_EN
    assign early_stop = det_found;
`else
    logic unused_det_found;
    assign unused_det_found = det_found;
    assign early_stop       = 1'b0;
`endif

    // Next-state logic for the scan sequence and pointer advance.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        drain_d    = drain_q;
        issue_scan = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_start) state_d = CLEAR;
            end
            CLEAR: begin
                ptr_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (early_stop) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else if (!disp_req) begin
                    issue_scan = 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = scan_start ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drain_q <= drain_d;
        end
    end

    // Read-port mux and tag for the read issued this cycle.
    always_comb begin
        fb_addr      = '0;
        tag_in       = '0;
        tag_in.owner = OWN_DISP;
        if (disp_req) begin
            fb_addr      = disp_addr;
            tag_in.valid = 1'b1;
            tag_in.owner = OWN_DISP;
            tag_in.addr  = disp_addr;
        end else if (issue_scan) begin
            fb_addr      = ptr_q;
            tag_in.valid = 1'b1;
            tag_in.owner = OWN_SCAN;
            tag_in.addr  = ptr_q;
        end
    end

    fb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Capture scan returns; pixel and address hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_valid_q <= 1'b0;
            scan_addr_q  <= '0;
            scan_pixel_q <= '0;
        end else begin
            scan_valid_q <= tag_out.valid && (tag_out.owner == OWN_SCAN);
            if (tag_out.valid && (tag_out.owner == OWN_SCAN)) begin
                scan_addr_q  <= tag_out.addr;
                scan_pixel_q <= fb_rdata;
            end
        end
    end

    assign disp_rvalid = tag_out.valid && (tag_out.owner == OWN_DISP);
    assign scan_valid  = scan_valid_q;
    assign scan_addr   = scan_addr_q;
    assign scan_pixel  = scan_pixel_q;
    assign det_clear_n = (state_q != CLEAR);
    assign scan_busy   = (state_q == CLEAR) || (state_q == SCAN) || (state_q == DRAIN);
    assign scan_done   = (state_q == DONE);

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter on a reduced 32x16 frame, RD_LAT = 2.
module tb_fb_scan_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned H   = 16;
    localparam int unsigned N   = W * H;
    localparam int unsigned LAT = 2;

    typedef struct {
        int addr;
        int cyc;
    } disp_t;

    logic        clk;
    logic        rst_n;
    logic        scan_start;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        disp_rvalid;
    logic [18:0] fb_addr;
    logic [11:0] fb_rdata;
    logic [18:0] scan_addr;
    logic [11:0] scan_pixel;
    logic        scan_valid;
    logic        det_clear_n;
    logic        det_found;
    logic        scan_busy;
    logic        scan_done;

    fb_scan_arbiter #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .RD_LAT       (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_start  (scan_start),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .fb_addr     (fb_addr),
        .fb_rdata    (fb_rdata),
        .scan_addr   (scan_addr),
        .scan_pixel  (scan_pixel),
        .scan_valid  (scan_valid),
        .det_clear_n (det_clear_n),
        .det_found   (det_found),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Preloaded frame-buffer content as a function of address.
    function automatic logic [11:0] pix(input int a);
        return 12'((a * 5) + 7);
    endfunction

    // Frame-buffer model with LAT-cycle read latency.
    logic [18:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= fb_addr;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign fb_rdata = pix(int'(rd_pipe[LAT-1]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard state shared by stimulus and monitor.
    int          scan_q[$];
    disp_t       disp_q[$];
    int          beats = 0;
    int          clr_lows = 0;
    int          done_count = 0;
    int          first_beat_cyc = -1;
    int          last_beat_cyc = 0;
    int          start_cyc = 0;
    int          exp_beats = N;
    logic [11:0] last_pix = '0;
    bit          mon_en = 0;
    int          mode = 0;
    int          burst_left = 0;

    // Monitor: pop and compare whenever the DUT presents a return.
    initial forever begin
        @(negedge clk);
        if (rst_n && mon_en) begin
            if (disp_rvalid) begin
                if (disp_q.size() == 0) check("disp_rvalid_spurious", 1, 0);
                else begin
                    disp_t d;
                    d = disp_q.pop_front();
                    check("disp_latency", cyc, d.cyc + LAT);
                    check("disp_data", int'(fb_rdata), int'(pix(d.addr)));
                end
            end
            if (disp_req) begin
                disp_t d;
                check("fb_addr_disp", int'(fb_addr), int'(disp_addr));
                d.addr = int'(disp_addr);
                d.cyc  = cyc;
                disp_q.push_back(d);
            end else if (!scan_busy) begin
                check("fb_addr_idle", int'(fb_addr), 0);
            end
            if (scan_valid) begin
                if (scan_q.size() == 0) check("scan_valid_spurious", 1, 0);
                else begin
                    int a;
                    a = scan_q.pop_front();
                    check("scan_addr", int'(scan_addr), a);
                    check("scan_pixel", int'(scan_pixel), int'(pix(a)));
                end
                beats++;
                if (beats == 1) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                last_pix      = scan_pixel;
            end else begin
                check("scan_pixel_hold", int'(scan_pixel), int'(last_pix));
            end
            if (!det_clear_n) begin
                clr_lows++;
                check("clear_cycle", cyc, start_cyc + 1);
                check("busy_in_clear", int'(scan_busy), 1);
            end
            if (scan_done) begin
                done_count++;
                check("done_after_last_beat", cyc, last_beat_cyc + 1);
                check("clear_low_count", clr_lows, 1);
                if (exp_beats >= 0) check("beats_at_done", beats, exp_beats);
                else check("early_stop_beats", int'(beats >= 41 && beats <= 41 + LAT + 3), 1);
                beats    = 0;
                clr_lows = 0;
            end
        end
    end

    // Background display traffic (and det_found noise when it must be ignored).
    initial forever begin
        @(posedge clk);
        #1;
        disp_addr = 19'($urandom_range(0, 19'h7FFFF));
        if (burst_left > 0) begin
            disp_req = 1'b1;
            burst_left--;
        end else if (mode == 1) begin
            disp_req = ($urandom_range(0, 99) < 40);
        end else begin
            disp_req = 1'b0;
        end
`ifndef FB_SCAN_EARLY_STOP_EN
        det_found = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
    end

    task automatic start_scan();
        @(posedge clk);
        #2;
        scan_start = 1'b1;
        start_cyc  = cyc;
        for (int i = 0; i < N; i++) scan_q.push_back(i);
        @(posedge clk);
        #2;
        scan_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", int'(done_count >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_rvalid"}, int'(disp_rvalid), 0);
        check({tag, "_fb_addr"}, int'(fb_addr), 0);
        check({tag, "_scan_valid"}, int'(scan_valid), 0);
        check({tag, "_scan_addr"}, int'(scan_addr), 0);
        check({tag, "_scan_pixel"}, int'(scan_pixel), 0);
        check({tag, "_det_clear_n"}, int'(det_clear_n), 1);
        check({tag, "_scan_busy"}, int'(scan_busy), 0);
        check({tag, "_scan_done"}, int'(scan_done), 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        scan_start = 1'b0;
        disp_req   = 1'b0;
        disp_addr  = '0;
        det_found  = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (4) @(posedge clk);

        // Scan 1: no display traffic, checks first-beat latency and full order.
        mode = 0;
        start_scan();
        wait_done(1, 4000);
        check("first_beat_latency", first_beat_cyc, start_cyc + 3 + LAT);

        // Scan 2: random display traffic, a 10-cycle burst and an ignored restart.
        mode = 1;
        start_scan();
        repeat (20) @(posedge clk);
        #2;
        scan_start = 1'b1;
        @(posedge clk);
        #2;
        scan_start = 1'b0;
        n = 0;
        while (beats < 100 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        burst_left = 10;
        // Restart in the same cycle scan_done is high: CLEAR must follow directly.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 4000);
        check("scan2_done_seen", int'(scan_done), 1);
        scan_start = 1'b1;
        start_cyc  = cyc;
        for (int i = 0; i < N; i++) scan_q.push_back(i);
        @(posedge clk);
        #2;
        scan_start = 1'b0;
        check("single_done_scan2", done_count, 2);

        // Scan 3: reset mid-scan with reads in flight.
        n = 0;
        while (beats < 200 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        mode = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        scan_q.delete();
        disp_q.delete();
        beats    = 0;
        clr_lows = 0;
        last_pix = '0;
        #1;
        check_reset_outputs("midscan_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        check("no_beats_after_reset", beats, 0);

        // Scan 4: full scan after reset with random traffic.
        mode = 1;
        start_scan();
        wait_done(3, 4000);
        mode = 0;

`ifdef FB_SCAN_EARLY_STOP_EN
        // Scan 5: detector fires around address 40, issuing stops early.
        exp_beats = -1;
        start_scan();
        n = 0;
        while (beats < 41 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        det_found = 1'b1;
        wait_done(4, 4000);
        det_found = 1'b0;
        repeat (2) @(posedge clk);
        scan_q.delete();
        exp_beats = N;
`endif

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Shares the single read port of the 640x480 RGB444 frame buffer between two requesters: the VGA display reader (fixed priority) and a background scan engine.
- The scan engine walks every pixel address once per triggered scan and streams (addr, pixel) pairs to the player-position detector.
- It clears the detector before each scan and reports completion.
- Sits between the frame-buffer BRAM, the VGA timing/reader path and the detector.

Parameters:
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.
- RD_LAT, 1, frame-buffer read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_start  in  1  one-cycle pulse; requests a full-frame scan.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  19  display read address.
- disp_rvalid  out  1  fb_rdata belongs to the display, RD_LAT cycles after its granted request.
- fb_addr  out  19  frame-buffer read address.
- fb_rdata  in  12  frame-buffer read data.
- scan_addr  out  19  address of the pixel on scan_pixel.
- scan_pixel  out  12  pixel data for the detector.
- scan_valid  out  1  scan_addr/scan_pixel valid.
- det_clear_n  out  1  active-low clear to the detector; held low for exactly one cycle per scan.
- det_found  in  1  detector has latched a position.
- scan_busy  out  1  scan in progress (CLEAR through DRAIN).
- scan_done  out  1  one-cycle pulse when the scan completes.

Behaviour:
Reset values:
- All outputs 0, except det_clear_n = 1.
- State = IDLE; scan pointer = 0; tag pipeline cleared.

State machine:
- IDLE: scan_start -> CLEAR.
- CLEAR: det_clear_n = 0 for one cycle; pointer <= 0; -> SCAN.
- SCAN: each cycle without disp_req, issue pointer on fb_addr and increment. After issuing address IMAGE_WIDTH*IMAGE_HEIGHT-1 (307199) -> DRAIN. The pointer never wraps.
- DRAIN: wait RD_LAT cycles for in-flight scan reads -> DONE.
- DONE: scan_done = 1 for one cycle -> IDLE.

Arbitration:
- disp_req always wins, in any state. fb_addr = disp_addr and the scan pointer holds.
- Otherwise, in SCAN, fb_addr = scan pointer. Otherwise fb_addr = 0 and no read is issued.
- No starvation guarantee for the scan; it progresses only in cycles without disp_req.

Return routing:
- A RD_LAT-deep shift register of tags (owner bit, valid bit, 19-bit addr) tracks each issued read.
- At the tail: display tag -> disp_rvalid = 1. Scan tag -> scan_valid = 1, scan_addr = tag addr, scan_pixel = fb_rdata.
- scan_addr/scan_pixel are registered in the same cycle as the tag exits. Total scan latency from issue = RD_LAT+1.

Simultaneous events and corner cases:
- scan_start while scan_busy is ignored.
- scan_start in the same cycle as scan_done: accepted; IDLE is skipped and the next state is CLEAR.
- disp_req in CLEAR or DRAIN is served normally and does not delay the state sequence.
- scan_pixel is stable and scan_valid = 0 in cycles without a scan return.
- Reset mid-scan: immediate abort. Outputs go to reset values and in-flight tags are discarded, so no stale scan_valid is produced.

Optional Feature:
- FB_SCAN_EARLY_STOP_EN defined: det_found = 1 during SCAN stops issuing immediately and goes to DRAIN. In-flight reads still return with scan_valid. scan_done pulses as usual.
- FB_SCAN_EARLY_STOP_EN undefined: det_found is ignored and every scan covers all 307200 pixels.

Decomposition:
- Shared package fb_pkg:
  - IMAGE_WIDTH, IMAGE_HEIGHT.
  - FB_DEPTH = 307200.
  - FB_AW = 19, PIX_W = 12.
  - state enum {IDLE, CLEAR, SCAN, DRAIN, DONE}.
  - owner enum {OWN_DISP, OWN_SCAN}.
- One natural sub-module: fb_rd_tag_pipe (parameterised RD_LAT tag delay line with valid/owner/addr).

Test Plan:
- Idle, no disp_req, scan_start pulse -> det_clear_n low exactly one cycle. First scan_valid with scan_addr=0 at RD_LAT+1 after the first issue. 307200 consecutive scan_valid beats, addresses 0..307199 in order. scan_done one cycle after the last beat.
- During scan, disp_req high for 10 cycles at pointer=1000 -> fb_addr = disp_addr for those 10 cycles. 10 disp_rvalid pulses RD_LAT later. Scan resumes at 1000 with no gap or duplicate addresses.
- Second scan_start mid-scan -> ignored. Exactly one scan_done, total beat count 307200.
- rst_n low at pointer 5000 with reads in flight -> next cycle all outputs at reset values. No scan_valid after reset release until a new scan_start.
- With FB_SCAN_EARLY_STOP_EN: detector fed all-black except addr 640 = 12'hFFF, det_found rises -> issuing stops. Beats stop at or shortly after 640 (at most RD_LAT+1 extra). scan_done pulses. Without the macro: full 307200 beats.
- RD_LAT=3 build, alternating disp_req every other cycle -> each disp_rvalid and scan_valid is attributed correctly to its owner with the matching address/data from a preloaded pattern (pixel = addr[11:0]).
